// File: rtl/packet_drain.sv
// packet_drain: reads one packet slot a byte at a time and streams it out with first/last framing.
// Define PKT_CRC_CHECK_EN to build the trailing XOR checksum check; otherwise crc_err is tied to 0.
module packet_drain #(
  parameter int unsigned PTR_SZ    = 2,
  parameter int unsigned PTR_IN_SZ = 4,
  parameter int unsigned UWIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PTR_SZ-1:0]    req_slot,
  output logic                 read_en,
  output logic [PTR_SZ-1:0]    raddr,
  output logic [PTR_IN_SZ-1:0] raddr_in,
  input  logic [UWIDTH-1:0]    rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [UWIDTH-1:0]    out_data,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 done,
  output logic [PTR_SZ-1:0]    done_slot,
  output logic                 crc_err,
  output logic                 len_err
);

  // Largest size field whose crc byte still fits inside the slot.
  localparam int unsigned MaxSize = (1 << PTR_IN_SZ) - 4;

  typedef enum logic [2:0] {StIdle, StFetch, StCapture, StSend, StDone} state_e;

  state_e               state_q, state_d;
  logic [PTR_SZ-1:0]    slot_q, slot_d;
  logic [PTR_IN_SZ-1:0] idx_q, idx_d;
  logic [UWIDTH-1:0]    size_q, size_d;
  logic [UWIDTH-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic                 len_err_q, len_err_d;

  logic                 is_size_byte;
  logic                 is_crc_byte;
  logic                 size_too_big;
  logic [UWIDTH:0]      crc_idx;

  assign is_size_byte = (idx_q == PTR_IN_SZ'(2));
  assign size_too_big = (rdata > UWIDTH'(MaxSize));
  assign crc_idx      = {1'b0, size_q} + (UWIDTH+1)'(3);
  // size_q is only meaningful once the size byte (index 2) has been captured.
  assign is_crc_byte  = (idx_q > PTR_IN_SZ'(2)) && ((UWIDTH+1)'(idx_q) == crc_idx);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    size_d    = size_q;
    data_d    = data_q;
    valid_d   = valid_q;
    first_d   = first_q;
    last_d    = last_q;
    len_err_d = len_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          slot_d    = req_slot;
          idx_d     = '0;
          size_d    = '0;
          len_err_d = 1'b0;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StCapture;
      StCapture: begin
        data_d  = rdata;
        valid_d = 1'b1;
        first_d = (idx_q == '0);
        last_d  = is_crc_byte;
        if (is_size_byte) begin
          size_d = rdata;
          if (size_too_big) begin
            last_d    = 1'b1;
            len_err_d = 1'b1;
          end
        end
        state_d = StSend;
      end
      StSend: begin
        if (out_ready) begin
          valid_d = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + PTR_IN_SZ'(1);
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      slot_q    <= '0;
      idx_q     <= '0;
      size_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      size_q    <= size_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef PKT_CRC_CHECK_EN
  logic [UWIDTH-1:0] acc_q, acc_d;
  logic              crc_err_q, crc_err_d;

  always_comb begin
    acc_d     = acc_q;
    crc_err_d = crc_err_q;
    if (state_q == StIdle && req_valid) begin
      acc_d     = '0;
      crc_err_d = 1'b0;
    end else if (state_q == StCapture) begin
      if (is_crc_byte) begin
        crc_err_d = (acc_q != rdata);
      end else begin
        acc_d = acc_q ^ rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err = done ? crc_err_q : 1'b0;
`else
  assign crc_err = 1'b0;
`endif

  assign req_ready = (state_q == StIdle);
  assign read_en   = (state_q == StFetch);
  assign raddr     = slot_q;
  assign raddr_in  = idx_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign done      = (state_q == StDone);
  assign done_slot = done ? slot_q : '0;
  assign len_err   = done ? len_err_q : 1'b0;

endmodule

// File: tb/tb_packet_drain.sv
// Randomised bench for packet_drain: a packet-level reference model checks every cycle,
// and directed packets pin exact latencies and framing. Honors PKT_CRC_CHECK_EN like the DUT.
module tb_packet_drain;

`ifdef PKT_CRC_CHECK_EN
  localparam bit CrcOn = 1'b1;
`else
  localparam bit CrcOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_slot;
  logic       read_en;
  logic [1:0] raddr;
  logic [3:0] raddr_in;
  logic [7:0] rdata = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_first;
  logic       out_last;
  logic       done;
  logic [1:0] done_slot;
  logic       crc_err;
  logic       len_err;

  packet_drain dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_slot  (req_slot),
    .read_en   (read_en),
    .raddr     (raddr),
    .raddr_in  (raddr_in),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .done      (done),
    .done_slot (done_slot),
    .crc_err   (crc_err),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Packet memory: registered read port.
  logic [7:0] mem [4][16];
  always @(posedge clk) if (read_en) rdata <= mem[raddr][raddr_in];

  int mode = 0;  // 0: ready high, 1: random ready, 2: stall 5 cycles on byte 3
  int stall_cnt = 0;
  int pkt_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (mode == 0) begin
      out_ready = 1'b1;
    end else if (mode == 1) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      if (out_valid && pkt_cnt == 3 && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor counters and packet-level model state.
  int n_cmp_m = 0;
  int n_fail_m = 0;
  int n_cmp_l = 0;
  int n_fail_l = 0;

  logic [7:0] exp_data[$];
  bit         busy = 0;
  bit         done_pend = 0;
  logic [1:0] cur_slot = '0;
  logic [1:0] exp_slot = '0;
  bit         exp_crc = 0;
  bit         exp_len = 0;
  int         acc_cyc = 0;
  bit         prev_valid = 0;
  bit         prev_ready = 0;
  logic [7:0] prev_data = '0;
  bit         prev_first = 0;
  bit         prev_last = 0;

  // Per-packet records for the directed literal checks.
  int         byte_cyc[$];
  logic [7:0] byte_val[$];
  int         first_seen = -1;
  int         last_seen = -1;
  int         done_cyc = -1;
  int         max_rin = -1;
  logic [1:0] rec_slot = '0;
  bit         rec_crc = 0;
  bit         rec_len = 0;

  task automatic mcheck(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp_m++;
    if (act !== req) begin
      n_fail_m++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic lcheck(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp_l++;
    if (act !== req) begin
      n_fail_l++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    int         n;
    logic [7:0] sz;
    logic [7:0] x;
    if (!rst) begin
      exp_data.delete();
      busy       = 0;
      done_pend  = 0;
      prev_valid = 0;
      prev_ready = 0;
      pkt_cnt    = 0;
    end else begin
      mcheck("req_ready", 32'(req_ready), 32'(!busy));
      if (read_en) begin
        mcheck("raddr", 32'(raddr), 32'(cur_slot));
        mcheck("raddr_in", 32'(raddr_in), 32'(pkt_cnt));
        mcheck("read_while_valid", 32'(out_valid), 32'(0));
        if (int'(raddr_in) > max_rin) max_rin = int'(raddr_in);
      end
      if (prev_valid && !prev_ready) begin
        mcheck("hold_valid", 32'(out_valid), 32'(1));
        mcheck("hold_data", 32'(out_data), 32'(prev_data));
        mcheck("hold_first", 32'(out_first), 32'(prev_first));
        mcheck("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid) begin
        mcheck("byte_pending", 32'(exp_data.size() > 0), 32'(1));
        if (exp_data.size() > 0) begin
          mcheck("out_data", 32'(out_data), 32'(exp_data[0]));
          mcheck("out_first", 32'(out_first), 32'(pkt_cnt == 0));
          mcheck("out_last", 32'(out_last), 32'(exp_data.size() == 1));
        end
        if (!(prev_valid && !prev_ready)) begin
          byte_cyc.push_back(cyc - acc_cyc);
          byte_val.push_back(out_data);
        end
        if (out_first) first_seen = int'(out_data);
        if (out_last) last_seen = int'(out_data);
        if (out_ready && exp_data.size() > 0) begin
          void'(exp_data.pop_front());
          pkt_cnt++;
        end
      end
      if (done) begin
        mcheck("done_expected", 32'(done_pend), 32'(1));
        mcheck("done_slot", 32'(done_slot), 32'(exp_slot));
        mcheck("crc_err", 32'(crc_err), 32'(exp_crc));
        mcheck("len_err", 32'(len_err), 32'(exp_len));
        mcheck("bytes_left_at_done", 32'(exp_data.size()), 32'(0));
        done_cyc  = cyc - acc_cyc;
        rec_slot  = done_slot;
        rec_crc   = crc_err;
        rec_len   = len_err;
        done_pend = 0;
        busy      = 0;
      end
      if (req_valid && req_ready) begin
        cur_slot = req_slot;
        sz = mem[req_slot][2];
        if (sz > 8'd12) begin
          n = 3;
          exp_len = 1;
        end else begin
          n = int'(sz) + 4;
          exp_len = 0;
        end
        exp_data.delete();
        for (int i = 0; i < n; i++) exp_data.push_back(mem[req_slot][i]);
        x = '0;
        for (int i = 0; i < n - 1; i++) x ^= mem[req_slot][i];
        exp_crc   = CrcOn && !exp_len && (x != mem[req_slot][n-1]);
        exp_slot  = req_slot;
        done_pend = 1;
        busy      = 1;
        acc_cyc   = cyc;
        pkt_cnt   = 0;
        byte_cyc.delete();
        byte_val.delete();
        first_seen = -1;
        last_seen  = -1;
        done_cyc   = -1;
        max_rin    = -1;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_first = out_first;
      prev_last  = out_last;
    end
  end

  task automatic start_req(input logic [1:0] s);
    bit got;
    got = 0;
    req_slot  = s;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lcheck("req_accepted", 32'(got), 32'(1));
  endtask

  task automatic run_pkt(input logic [1:0] s);
    bit got;
    start_req(s);
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    lcheck("done_seen", 32'(got), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    lcheck({tag, "_req_ready"}, 32'(req_ready), 32'(1));
    lcheck({tag, "_read_en"}, 32'(read_en), 32'(0));
    lcheck({tag, "_raddr"}, 32'({raddr, raddr_in}), 32'(0));
    lcheck({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    lcheck({tag, "_out_data"}, 32'(out_data), 32'(0));
    lcheck({tag, "_framing"}, 32'({out_first, out_last}), 32'(0));
    lcheck({tag, "_done"}, 32'({done, done_slot}), 32'(0));
    lcheck({tag, "_errs"}, 32'({crc_err, len_err}), 32'(0));
  endtask

  initial begin
    logic [7:0] pkt_a [7];
    logic [1:0] s;
    logic [7:0] sz;
    logic [7:0] x;
    bit         got;

    pkt_a = '{8'd10, 8'd5, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
    for (int k = 0; k < 4; k++) for (int i = 0; i < 16; i++) mem[k][i] = 8'h00;
    for (int i = 0; i < 7; i++) begin
      mem[0][i] = pkt_a[i];
      mem[2][i] = pkt_a[i];
    end
    mem[2][6] = 8'd14;
    mem[1][0] = 8'd4; mem[1][1] = 8'd6; mem[1][2] = 8'd13; mem[1][3] = 8'd99;
    mem[3][0] = 8'd7; mem[3][1] = 8'd9; mem[3][2] = 8'd0;  mem[3][3] = 8'd14;

    rst = 1'b0;
    req_valid = 1'b0;
    req_slot = '0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Nominal packet, ready always high.
    run_pkt(2'd0);
    lcheck("p0_nbytes", 32'(byte_val.size()), 32'(7));
    for (int i = 0; i < 7 && i < byte_val.size(); i++) begin
      lcheck("p0_byte_cycle", 32'(byte_cyc[i]), 32'(3 + 3 * i));
      lcheck("p0_byte_value", 32'(byte_val[i]), 32'(pkt_a[i]));
    end
    lcheck("p0_first_byte", 32'(first_seen), 32'(10));
    lcheck("p0_last_byte", 32'(last_seen), 32'(15));
    lcheck("p0_done_cycle", 32'(done_cyc), 32'(22));
    lcheck("p0_done_slot", 32'(rec_slot), 32'(0));
    lcheck("p0_errs", 32'({rec_crc, rec_len}), 32'(0));

    // Bad checksum in slot 2.
    run_pkt(2'd2);
    lcheck("p2_done_slot", 32'(rec_slot), 32'(2));
    lcheck("p2_crc_err", 32'(rec_crc), 32'(CrcOn));
    lcheck("p2_len_err", 32'(rec_len), 32'(0));

    // Oversized size field: stops after the size byte.
    run_pkt(2'd1);
    lcheck("p1_nbytes", 32'(byte_val.size()), 32'(3));
    lcheck("p1_last_byte", 32'(last_seen), 32'(13));
    lcheck("p1_len_err", 32'(rec_len), 32'(1));
    lcheck("p1_max_raddr_in", 32'(max_rin), 32'(2));
    lcheck("p1_done_cycle", 32'(done_cyc), 32'(10));

    // Backpressure: byte 3 stalled for 5 cycles.
    mode = 2;
    run_pkt(2'd0);
    lcheck("bp_byte3_cycle", 32'(byte_cyc.size() > 3 ? byte_cyc[3] : -1), 32'(12));
    lcheck("bp_byte4_cycle", 32'(byte_cyc.size() > 4 ? byte_cyc[4] : -1), 32'(20));
    lcheck("bp_byte3_value", 32'(byte_val.size() > 3 ? byte_val[3] : 8'hff), 32'(0));
    lcheck("bp_done_cycle", 32'(done_cyc), 32'(27));
    lcheck("bp_errs", 32'({rec_crc, rec_len}), 32'(0));
    mode = 0;

    // Zero-size packet.
    run_pkt(2'd3);
    lcheck("p3_nbytes", 32'(byte_val.size()), 32'(4));
    lcheck("p3_last_byte", 32'(last_seen), 32'(14));
    lcheck("p3_errs", 32'({rec_crc, rec_len}), 32'(0));
    lcheck("p3_done_slot", 32'(rec_slot), 32'(3));

    // Reset while byte 4 is on the output, then drain the same slot again.
    start_req(2'd0);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      #1;
      if (byte_val.size() >= 5) got = 1;
    end
    lcheck("reached_byte4", 32'(got), 32'(1));
    #1 rst = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    run_pkt(2'd0);
    lcheck("rr_nbytes", 32'(byte_val.size()), 32'(7));
    lcheck("rr_first_byte", 32'(first_seen), 32'(10));
    lcheck("rr_byte0_cycle", 32'(byte_cyc.size() > 0 ? byte_cyc[0] : -1), 32'(3));
    lcheck("rr_done_slot", 32'(rec_slot), 32'(0));

    // Random packets with random backpressure.
    mode = 1;
    for (int p = 0; p < 40; p++) begin
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) sz = 8'($urandom_range(13, 255));
      else sz = 8'($urandom_range(0, 12));
      for (int i = 0; i < 16; i++) mem[s][i] = 8'($urandom);
      mem[s][2] = sz;
      if (sz <= 8'd12 && $urandom_range(0, 3) != 0) begin
        x = '0;
        for (int i = 0; i < int'(sz) + 3; i++) x ^= mem[s][i];
        mem[s][int'(sz) + 3] = x;
      end
      run_pkt(s);
    end
    mode = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp_m + n_cmp_l, n_fail_m + n_fail_l);
    $finish;
  end

endmodule
